// File: rtl/change_event_pkg.sv
// change_event_pkg: shared widths, state encoding and event record for the change scheduler
package change_event_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int DATA_W_DEF = 4;
    localparam int TS_W_DEF   = 16;

    // Channel index width, never below one bit so ev_ch always exists
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int CH_W_DEF = clog2_min1(NUM_CH_DEF);

    typedef enum logic {
        IDLE,
        HOLD
    } out_state_e;

    typedef struct packed {
        logic [CH_W_DEF-1:0]   ch;
        logic [DATA_W_DEF-1:0] value;
        logic [TS_W_DEF-1:0]   tstamp;
    } event_t;

endpackage

// File: rtl/change_event_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   idx_o
);

    logic            found;
    logic [CH_W-1:0] pos;

    // Scan ptr, ptr+1, ... wrapping at NUM_CH; first hit wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pos = CH_W'((int'(ptr_i) + k) % NUM_CH);
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

endmodule

// File: rtl/change_event_scheduler.sv
// change_event_scheduler: per-channel change capture with round-robin valid/ready event output
module change_event_scheduler
    import change_event_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TS_W   = TS_W_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_CH*DATA_W-1:0]          data_in,
    output logic                              ev_valid,
    input  logic                              ev_ready,
    output logic [clog2_min1(NUM_CH)-1:0]     ev_ch,
    output logic [DATA_W-1:0]                 ev_value,
    output logic [TS_W-1:0]                   ev_time,
    output logic [NUM_CH-1:0]                 ovf,
    input  logic                              ovf_clr
);

    localparam int CH_W = clog2_min1(NUM_CH);

    out_state_e                 state_q, state_d;
    logic [TS_W-1:0]            ts_q;
    logic                       armed_q;
    logic [NUM_CH*DATA_W-1:0]   prev_q;
    logic [NUM_CH*DATA_W-1:0]   cap_val_q, cap_val_d;
    logic [NUM_CH*TS_W-1:0]     cap_ts_q, cap_ts_d;
    logic [NUM_CH-1:0]          pending_q, pending_d;
    logic [NUM_CH-1:0]          ovf_q, ovf_d;
    logic [CH_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]            ev_ch_q, ev_ch_d;
    logic [DATA_W-1:0]          ev_value_q, ev_value_d;
    logic [TS_W-1:0]            ev_time_q, ev_time_d;
    logic [NUM_CH-1:0]          change, gnt, gnt_mask;
    logic [CH_W-1:0]            gnt_idx;
    logic                       grant;

    rr_arbiter #(
        .NUM_CH(NUM_CH),
        .CH_W  (CH_W)
    ) u_arb (
        .req_i(pending_q),
        .ptr_i(rr_ptr_q),
        .gnt_o(gnt),
        .idx_o(gnt_idx)
    );

    // A channel changed when armed and its input differs from the last seen value
    always_comb begin
        change = '0;
        for (int i = 0; i < NUM_CH; i++)
            change[i] = armed_q && (data_in[i*DATA_W +: DATA_W] != prev_q[i*DATA_W +: DATA_W]);
    end

    // Capture, pending and overwrite bookkeeping; a same-edge grant reads the old capture
    always_comb begin
        cap_val_d = cap_val_q;
        cap_ts_d  = cap_ts_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (change[i]) begin
                cap_val_d[i*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
                cap_ts_d[i*TS_W +: TS_W]      = ts_q;
            end
        end
        gnt_mask  = grant ? gnt : '0;
        pending_d = (pending_q & ~gnt_mask) | change;
        ovf_d     = ovf_clr ? '0 : (ovf_q | (change & pending_q & ~gnt_mask));
    end

    // Output FSM: load a new event whenever the slot is empty or being drained
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        ev_ch_d    = ev_ch_q;
        ev_value_d = ev_value_q;
        ev_time_d  = ev_time_q;
        grant      = (state_q == IDLE || ev_ready) && (|pending_q);
        if (grant) begin
            state_d    = HOLD;
            ev_ch_d    = gnt_idx;
            ev_value_d = cap_val_q[gnt_idx*DATA_W +: DATA_W];
            ev_time_d  = cap_ts_q[gnt_idx*TS_W +: TS_W];
            rr_ptr_d   = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        end else if (state_q == HOLD && ev_ready) begin
            state_d = IDLE;
        end
    end

    // State registers; prev simply tracks data_in since unchanged channels already match
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            armed_q    <= 1'b0;
            prev_q     <= '0;
            cap_val_q  <= '0;
            cap_ts_q   <= '0;
            pending_q  <= '0;
            ovf_q      <= '0;
            rr_ptr_q   <= '0;
            ev_ch_q    <= '0;
            ev_value_q <= '0;
            ev_time_q  <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_q + TS_W'(1);
            armed_q    <= 1'b1;
            prev_q     <= data_in;
            cap_val_q  <= cap_val_d;
            cap_ts_q   <= cap_ts_d;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
            rr_ptr_q   <= rr_ptr_d;
            ev_ch_q    <= ev_ch_d;
            ev_value_q <= ev_value_d;
            ev_time_q  <= ev_time_d;
        end
    end

    assign ev_valid = (state_q == HOLD);
    assign ev_ch    = ev_ch_q;
    assign ev_value = ev_value_q;
    assign ev_time  = ev_time_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_change_event_scheduler.sv
// tb_change_event_scheduler: directed checks of capture, arbitration, overflow, wrap and reset
module tb_change_event_scheduler;
    import change_event_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = '0;
    logic        ev_valid;
    logic        ev_ready = 1'b1;
    logic [1:0]  ev_ch;
    logic [3:0]  ev_value;
    logic [15:0] ev_time;
    logic [3:0]  ovf;
    logic        ovf_clr = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          vcount;
    logic [15:0] tsm;
    logic [15:0] t0;

    change_event_scheduler dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_ch   (ev_ch),
        .ev_value(ev_value),
        .ev_time (ev_time),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input event_t e);
        chk({tag, ".valid"}, 32'(ev_valid), 32'd1);
        chk({tag, ".ch"}, 32'(ev_ch), 32'(e.ch));
        chk({tag, ".value"}, 32'(ev_value), 32'(e.value));
        chk({tag, ".time"}, 32'(ev_time), 32'(e.tstamp));
    endtask

    // tsm mirrors the DUT timestamp: value of ts_cnt between edges
    task automatic tick();
        @(posedge clock);
        tsm = tsm + 16'd1;
        #1;
    endtask

    task automatic do_reset(input logic [15:0] base);
        reset    = 1'b1;
        data_in  = base;
        ev_ready = 1'b1;
        ovf_clr  = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tsm   = '0;
    endtask

    initial begin
        tsm = '0;
        // 1: reset state, constant input
        do_reset(16'h0000);
        chk("t1_rst_valid", 32'(ev_valid), 0);
        chk("t1_rst_ch", 32'(ev_ch), 0);
        chk("t1_rst_value", 32'(ev_value), 0);
        chk("t1_rst_time", 32'(ev_time), 0);
        chk("t1_rst_ovf", 32'(ovf), 0);
        vcount = 0;
        repeat (20) begin
            tick();
            vcount += int'(ev_valid);
        end
        chk("t1_no_events", 32'(vcount), 0);
        chk("t1_ovf", 32'(ovf), 0);

        // 2: single change at ts=10, exactly one cycle of valid, re-write is silent
        do_reset(16'h0000);
        repeat (10) tick();
        data_in = 16'h0005;
        tick();
        chk("t2_latency", 32'(ev_valid), 0);
        tick();
        chk_ev("t2_ev", '{ch: 2'd0, value: 4'd5, tstamp: 16'd10});
        tick();
        chk("t2_one_cycle", 32'(ev_valid), 0);
        data_in = 16'h0005;
        vcount = 0;
        repeat (4) begin
            tick();
            vcount += int'(ev_valid);
        end
        chk("t2_rewrite", 32'(vcount), 0);

        // 3: four simultaneous changes, round-robin order twice
        do_reset(16'h0000);
        tick();
        data_in = 16'h4321;
        tick();
        chk("t3_latency", 32'(ev_valid), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_ev("t3_a", '{ch: 2'(k), value: 4'(k + 1), tstamp: 16'd1});
        end
        tick();
        chk("t3_drain", 32'(ev_valid), 0);
        t0 = tsm;
        data_in = 16'h8765;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_ev("t3_b", '{ch: 2'(k), value: 4'(k + 5), tstamp: t0});
        end
        tick();
        chk("t3_drain2", 32'(ev_valid), 0);

        // 4: hold with ready low, overwrite on ch2, clear, clear-wins
        do_reset(16'h0500);
        tick();
        ev_ready = 1'b0;
        data_in = 16'h0501;
        tick();
        tick();
        chk_ev("t4_held", '{ch: 2'd0, value: 4'd1, tstamp: 16'd1});
        data_in = 16'h0A01;
        tick();
        chk("t4_no_ovf_yet", 32'(ovf), 0);
        data_in = 16'h0501;
        tick();
        chk("t4_ovf_set", 32'(ovf), 32'h4);
        tick();
        tick();
        chk_ev("t4_still_held", '{ch: 2'd0, value: 4'd1, tstamp: 16'd1});
        ev_ready = 1'b1;
        tick();
        chk_ev("t4_ch2", '{ch: 2'd2, value: 4'd5, tstamp: 16'd4});
        tick();
        chk("t4_drain", 32'(ev_valid), 0);
        chk("t4_ovf_sticky", 32'(ovf), 32'h4);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", 32'(ovf), 0);
        ev_ready = 1'b0;
        data_in = 16'h0511;
        tick();
        tick();
        data_in = 16'h0521;
        tick();
        data_in = 16'h0531;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4_clr_wins", 32'(ovf), 0);
        data_in = 16'h0541;
        tick();
        chk("t4_ovf_ch1", 32'(ovf), 32'h2);
        ev_ready = 1'b1;
        tick();
        chk("t4_ch1_value", 32'(ev_value), 32'h4);
        chk("t4_ch1_ch", 32'(ev_ch), 32'h1);
        tick();
        chk("t4_drain2", 32'(ev_valid), 0);

        // 5: timestamp wrap
        do_reset(16'h0000);
        tick();
        while (tsm != 16'hFFFF) tick();
        data_in = 16'h0001;
        tick();
        data_in = 16'h0011;
        tick();
        chk_ev("t5_pre_wrap", '{ch: 2'd0, value: 4'd1, tstamp: 16'hFFFF});
        tick();
        chk_ev("t5_post_wrap", '{ch: 2'd1, value: 4'd1, tstamp: 16'h0000});
        tick();
        chk("t5_drain", 32'(ev_valid), 0);

        // 6: async reset with an event in flight and more pending
        ev_ready = 1'b0;
        data_in = 16'h0777;
        tick();
        tick();
        chk("t6_busy", 32'(ev_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 32'(ev_valid), 0);
        chk("t6_async_ovf", 32'(ovf), 0);
        do_reset(16'h9999);
        tick();
        vcount = 0;
        repeat (5) begin
            tick();
            vcount += int'(ev_valid);
        end
        chk("t6_no_stale", 32'(vcount), 0);
        data_in = 16'h999A;
        tick();
        tick();
        chk_ev("t6_fresh", '{ch: 2'd0, value: 4'hA, tstamp: 16'd6});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
